// File: rtl/alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the shared-ALU arbiter and the
// response consumer.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_op;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// One combinational 32-bit ALU shared by two valid/ready requesters through a
// round-robin arbiter; a single registered result slot tagged with the requester id.
module alu32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        zero
);
    always_comb begin
        result = '0;
        case (op)
            4'd0: result = a + b;
            4'd1: result = a - b;
            4'd2: result = a & b;
            4'd3: result = a | b;
            4'd4: result = a ^ b;
            4'd5: result = {31'd0, $signed(a) < $signed(b)};
            4'd6: result = a << b[4:0];
            4'd7: result = a >> b[4:0];
            default: result = '0;
        endcase
        zero = (result == '0);
    end
endmodule

module alu_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} buf_state_t;

    buf_state_t  state;
    logic        last_grant;
    logic        id_q;
    logic [31:0] result_q;
    logic        zero_q;

    logic        can_accept;
    logic        grant_valid;
    logic        grant;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;

    // Draining the slot and refilling it happen on the same edge.
    always_comb begin
        can_accept  = (state == EMPTY) || bus.rsp_ready;
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (can_accept) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant       = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant       = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant       = 1'b1;
            end
        end
    end

    always_comb begin
        if (grant_valid && grant) begin
            alu_a  = bus.req1_a;
            alu_b  = bus.req1_b;
            alu_op = bus.req1_op;
        end else begin
            alu_a  = bus.req0_a;
            alu_b  = bus.req0_b;
            alu_op = bus.req0_op;
        end
    end

    alu32 alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= ~FIRST_PRIO;
            id_q       <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
        end else if (grant_valid) begin
            state      <= FULL;
            last_grant <= grant;
            id_q       <= grant;
            result_q   <= alu_result;
            zero_q     <= alu_zero;
        end else if ((state == FULL) && bus.rsp_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.req0_ready = grant_valid && !grant;
    assign bus.req1_ready = grant_valid && grant;
    assign bus.rsp_valid  = (state == FULL);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
endmodule
